pipe_stage_buffer: RTL

PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

---
 rtl/pipe_stage_buffer.sv | 113 +++++++++++
 1 files changed

// File: rtl/pipe_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buffer
// Description : Two-entry pipeline skid buffer (main + skid) with registered
//               in_ready, synchronous flush and a saturating stall counter.
// Revision    : 1.0
// ============================================================================
module pipe_stage_buffer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_STALL_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_stall_count;
    logic             w_accept;
    logic             w_consume;
    logic             w_out_valid;
    logic             w_stall;

    assign w_out_valid = (r_state != S_EMPTY);
    assign w_accept    = in_valid & r_in_ready;
    assign w_consume   = w_out_valid & out_ready;
    assign w_stall     = w_out_valid & ~out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_main_nxt  = in_data;
                    w_state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (w_accept && w_consume) begin
                    w_main_nxt  = in_data;
                end else if (w_accept) begin
                    w_skid_nxt  = in_data;
                    w_state_nxt = S_TWO;
                end else if (w_consume) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_consume) begin
                    w_main_nxt  = r_skid;
                    w_state_nxt = S_ONE;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
        // Flush wins over every transition; entry contents become don't-care.
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_EMPTY;
            r_main        <= '0;
            r_skid        <= '0;
            r_in_ready    <= 1'b1;
            r_stall_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            // Registered ready: look ahead at the next state so out_ready never
            // reaches in_ready combinationally.
            r_in_ready <= (w_state_nxt != S_TWO);
            if (w_stall && (r_stall_count != c_STALL_MAX)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = w_out_valid;
    assign out_data    = r_main;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire
